// File: rtl/qpsk_frame_sync.sv
// Frame synchroniser behind the QPSK demodulator: hunts a 32-bit sync word, reads a length
// byte, packs the payload symbols into bytes and queues them in a small FWFT FIFO.
module qpsk_frame_sync #(
  parameter logic [31:0] SYNC_WORD    = 32'h1ACFFC1D,
  parameter int          SYNC_MAX_ERR = 0,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          TIMEOUT_CYC  = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] frame_len,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_err,
  output logic       overflow,
  output logic       locked
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {HUNT, HEADER, PAYLOAD} state_t;

  state_t         state, state_next;
  logic [31:0]    shreg;
  logic [4:0]     fill;
  logic [1:0]     sym_cnt;
  logic [7:0]     byte_sr;
  logic [7:0]     remaining;
  logic [IW-1:0]  idle;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;

  function automatic int popcount32(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  logic [31:0] shreg_next;
  logic [7:0]  byte_next;
  logic [4:0]  fill_inc;
  logic        byte_done, sync_hit, timeout, start_now, end_now, push_req, push, pop;

  assign shreg_next = {shreg[29:0], sym_in};
  assign byte_next  = {byte_sr[5:0], sym_in};
  assign fill_inc   = (fill == 5'd16) ? 5'd16 : fill + 5'd1;
  assign byte_done  = sym_valid && (sym_cnt == 2'd3);
  assign timeout    = (state != HUNT) && !sym_valid && (idle == IW'(TIMEOUT_CYC - 1));

  // NOTE: every output of a combinational block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_next = state;
    sync_hit   = 1'b0;
    start_now  = 1'b0;
    end_now    = 1'b0;
    push_req   = 1'b0;
    case (state)
      HUNT: begin
        if (sym_valid && fill_inc == 5'd16 &&
            popcount32(shreg_next ^ SYNC_WORD) <= SYNC_MAX_ERR) begin
          sync_hit   = 1'b1;
          state_next = HEADER;
        end
      end
      HEADER: begin
        if (timeout) state_next = HUNT;
        else if (byte_done) begin
          start_now = 1'b1;
          if (byte_next == 8'd0) begin
            end_now    = 1'b1;
            state_next = HUNT;
          end else begin
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (timeout) state_next = HUNT;
        else if (byte_done) begin
          push_req = 1'b1;
          if (remaining == 8'd1) begin
            end_now    = 1'b1;
            state_next = HUNT;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      fill        <= '0;
      sym_cnt     <= '0;
      byte_sr     <= '0;
      remaining   <= '0;
      idle        <= '0;
      frame_len   <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (state == HUNT) begin
        sym_cnt <= '0;
        byte_sr <= '0;
        idle    <= '0;
        // Clearing on the hit means the hunt restarts from empty on every return to HUNT.
        if (sync_hit) begin
          shreg <= '0;
          fill  <= '0;
        end else if (sym_valid) begin
          shreg <= shreg_next;
          fill  <= fill_inc;
        end
      end else begin
        idle <= sym_valid ? '0 : idle + IW'(1);
        if (sym_valid) begin
          sym_cnt <= sym_cnt + 2'd1;
          byte_sr <= byte_next;
        end
      end
      if (start_now) begin
        frame_len <= byte_next;
        remaining <= byte_next;
      end else if (push_req) begin
        remaining <= remaining - 8'd1;
      end
      frame_start <= start_now;
      frame_end   <= end_now;
      frame_err   <= timeout;
    end
  end

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign pop  = (count != '0) && byte_ready;
  assign push = push_req && ((count != FULL_CNT) || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; only pointers and count do, and byte_data is gated by byte_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= byte_next;
  end

  assign byte_valid = (count != '0);
  assign byte_data  = byte_valid ? mem[rd_ptr] : 8'd0;
  assign locked     = (state != HUNT);

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// Directed bench for qpsk_frame_sync: table of single-byte frames plus hand-written
// sequences for threshold, zero length, overflow, timeout and asynchronous reset.
module tb_qpsk_frame_sync;

  localparam int TO = 400;
  localparam logic [31:0] SYNC = 32'h1ACFFC1D;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       byte_ready;

  logic [7:0] byte_data, frame_len;
  logic       byte_valid, frame_start, frame_end, frame_err, overflow, locked;
  logic [7:0] byte_data1, frame_len1;
  logic       byte_valid1, frame_start1, frame_end1, frame_err1, overflow1, locked1;

  always #5 clk = ~clk;

  qpsk_frame_sync #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .frame_len(frame_len), .frame_start(frame_start), .frame_end(frame_end),
    .frame_err(frame_err), .overflow(overflow), .locked(locked)
  );

  qpsk_frame_sync #(.SYNC_MAX_ERR(1), .TIMEOUT_CYC(TO)) dut1 (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .byte_data(byte_data1), .byte_valid(byte_valid1), .byte_ready(byte_ready),
    .frame_len(frame_len1), .frame_start(frame_start1), .frame_end(frame_end1),
    .frame_err(frame_err1), .overflow(overflow1), .locked(locked1)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int         n_start, n_end, n_err, n_same, n_start1;
  logic [7:0] last_len, last_len1;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (frame_start) begin
      n_start++;
      last_len = frame_len;
      if (frame_end) n_same++;
    end
    if (frame_end) n_end++;
    if (frame_err) n_err++;
    if (byte_valid && byte_ready) got.push_back(byte_data);
    if (frame_start1) begin
      n_start1++;
      last_len1 = frame_len1;
    end
  end

  task automatic clear_mon();
    n_start = 0; n_end = 0; n_err = 0; n_same = 0; n_start1 = 0;
    got.delete();
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] s);
    @(posedge clk); #1;
    sym_in = s; sym_valid = 1'b1;
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) send_sym(b[2*i +: 2]);
  endtask

  task automatic send_sync(input logic [31:0] w);
    for (int i = 15; i >= 0; i--) send_sym(w[2*i +: 2]);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [7:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  typedef struct {
    logic [1:0] s0, s1, s2, s3;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'd2, 2'd2, 2'd1, 2'd1, 8'hA5};
    vecs[1] = '{2'd0, 2'd3, 2'd3, 2'd0, 8'h3C};
    vecs[2] = '{2'd3, 2'd3, 2'd3, 2'd3, 8'hFF};
    vecs[3] = '{2'd0, 2'd0, 2'd0, 2'd1, 8'h01};
    vecs[4] = '{2'd1, 2'd0, 2'd0, 2'd0, 8'h40};
    vecs[5] = '{2'd3, 2'd0, 2'd2, 2'd1, 8'hC9};

    reset = 1'b1; sym_in = 2'd0; sym_valid = 1'b0; byte_ready = 1'b1;
    clear_mon();
    #1;
    check("reset byte_valid", byte_valid, 0);
    check("reset frame_len", frame_len, 0);
    check("reset locked", locked, 0);
    check("reset overflow", overflow, 0);
    settle(2);
    reset = 1'b0;

    // Symbol packing: one-byte frames built from the table.
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send_sync(SYNC);
      send_byte(8'd1);
      send_sym(vecs[v].s0); send_sym(vecs[v].s1);
      send_sym(vecs[v].s2); send_sym(vecs[v].s3);
      settle(4);
      check($sformatf("vec%0d count", v), got.size(), 1);
      check($sformatf("vec%0d byte", v), got_at(0), vecs[v].exp_byte);
      check($sformatf("vec%0d end", v), n_end, 1);
    end

    // Basic frame LEN=3.
    clear_mon();
    send_sync(SYNC);
    check("t1 locked after sync", locked, 1);
    send_byte(8'd3);
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hFF);
    settle(5);
    check("t1 starts", n_start, 1);
    check("t1 len", last_len, 3);
    check("t1 count", got.size(), 3);
    check("t1 b0", got_at(0), 8'hA5);
    check("t1 b1", got_at(1), 8'h3C);
    check("t1 b2", got_at(2), 8'hFF);
    check("t1 ends", n_end, 1);
    check("t1 unlocked", locked, 0);
    check("t1 len held", frame_len, 3);

    // One flipped sync bit: strict instance ignores, tolerant instance locks.
    clear_mon();
    send_sync(SYNC ^ 32'h1);
    send_byte(8'd2);
    send_byte(8'h11); send_byte(8'h22);
    settle(5);
    check("t2 strict starts", n_start, 0);
    check("t2 strict locked", locked, 0);
    check("t2 tol starts", n_start1, 1);
    check("t2 tol len", last_len1, 2);

    // LEN=0 then back-to-back sync.
    clear_mon();
    send_sync(SYNC);
    send_byte(8'd0);
    settle(2);
    check("t3 start+end same", n_same, 1);
    check("t3 no push", got.size(), 0);
    check("t3 hunting", locked, 0);
    send_sync(SYNC);
    send_byte(8'd1);
    send_byte(8'h5A);
    settle(4);
    check("t3 second start", n_start, 2);
    check("t3 second byte", got_at(0), 8'h5A);
    check("t3 len", frame_len, 1);

    // Overflow with stalled consumer.
    clear_mon();
    byte_ready = 1'b0;
    send_sync(SYNC);
    send_byte(8'd10);
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    settle(3);
    check("t4 overflow", overflow, 1);
    check("t4 end", n_end, 1);
    check("t4 head stable", byte_data, 8'h00);
    byte_ready = 1'b1;
    settle(12);
    check("t4 drained", got.size(), 8);
    check("t4 first", got_at(0), 8'h00);
    check("t4 last", got_at(7), 8'h07);
    check("t4 empty", byte_valid, 0);

    // Push and pop on the same edge while full.
    reset_dut();
    clear_mon();
    byte_ready = 1'b0;
    send_sync(SYNC);
    send_byte(8'd9);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    send_sym(2'd0); send_sym(2'd0); send_sym(2'd2);
    @(posedge clk); #1;
    sym_in = 2'd0; sym_valid = 1'b1; byte_ready = 1'b1;
    @(posedge clk); #1;
    sym_valid = 1'b0; byte_ready = 1'b0;
    settle(2);
    check("t4b no overflow", overflow, 0);
    check("t4b one popped", got.size(), 1);
    check("t4b still full", byte_valid, 1);
    byte_ready = 1'b1;
    settle(12);
    check("t4b total", got.size(), 9);
    check("t4b last", got_at(8), 8'h08);

    // Timeout mid-payload.
    reset_dut();
    clear_mon();
    byte_ready = 1'b0;
    send_sync(SYNC);
    send_byte(8'd5);
    send_byte(8'hB4); send_byte(8'h96);
    send_sym(2'd3); send_sym(2'd1);
    settle(TO - 10);
    check("t5 no early err", n_err, 0);
    check("t5 still locked", locked, 1);
    for (int i = 0; i < 50 && n_err == 0; i++) @(negedge clk);
    check("t5 err pulse", n_err, 1);
    settle(2);
    check("t5 hunting", locked, 0);
    check("t5 no end", n_end, 0);
    byte_ready = 1'b1;
    settle(4);
    check("t5 kept bytes", got.size(), 2);
    check("t5 b0", got_at(0), 8'hB4);
    check("t5 b1", got_at(1), 8'h96);
    send_sync(SYNC);
    send_byte(8'd2);
    send_byte(8'hC3); send_byte(8'h7E);
    settle(4);
    check("t5 recover count", got.size(), 4);
    check("t5 recover b", got_at(3), 8'h7E);
    check("t5 recover end", n_end, 1);

    // Asynchronous reset mid-payload.
    clear_mon();
    byte_ready = 1'b0;
    send_sync(SYNC);
    send_byte(8'd10);
    for (int i = 0; i < 9; i++) send_byte(8'(i + 16));
    check("t6 pre overflow", overflow, 1);
    #2 reset = 1'b1;
    #1;
    check("t6 byte_valid", byte_valid, 0);
    check("t6 byte_data", byte_data, 0);
    check("t6 frame_len", frame_len, 0);
    check("t6 locked", locked, 0);
    check("t6 overflow", overflow, 0);
    check("t6 pulses", {frame_start, frame_end, frame_err}, 0);
    settle(2);
    reset = 1'b0;
    byte_ready = 1'b1;
    clear_mon();
    send_sync(SYNC);
    send_byte(8'd3);
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hFF);
    settle(5);
    check("t6 len", last_len, 3);
    check("t6 count", got.size(), 3);
    check("t6 b0", got_at(0), 8'hA5);
    check("t6 b2", got_at(2), 8'hFF);
    check("t6 end", n_end, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
